// File: rtl/pulse_burst_gen_pkg.sv
// rtl/pulse_burst_gen_pkg.sv - shared state encoding, widths and count helpers for the pulse burst generator
package pulse_burst_gen_pkg;

    // Width of the pulse-count field and the remaining-pulse counter.
    localparam int CNT_W = 3;
    // Width of the HIGH/LOW phase timer (phase lengths 1..15).
    localparam int TMR_W = 4;
    // A count field of all zeros requests the maximum burst of 8 pulses.
    localparam bit COUNT_ZERO_MEANS_8 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of pulses a stored count value stands for.
    function automatic logic [CNT_W:0] pulses_from_count(input logic [CNT_W-1:0] c);
        if (COUNT_ZERO_MEANS_8 && (c == '0)) begin
            return (CNT_W+1)'(8);
        end
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/pulse_burst_gen_down_counter3.sv
// rtl/pulse_burst_gen_down_counter3.sv - remaining-pulse down counter for the burst generator
//
// Ports:
//   clk_i         clock, rising edge
//   nreset_i      asynchronous active-low reset, clears the count
//   clr_i         synchronous clear (highest priority)
//   load_i        load load_val_i
//   load_val_i    count to load (0 stands for 8)
//   dec_i         decrement by one (8, stored as 0, steps to 7)
//   count_o       current stored count
//   dec_to_zero_o zero flag of the decremented value: the next decrement ends the burst
module down_counter3
    import pulse_burst_gen_pkg::*;
(
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             dec_to_zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            // Natural modulo-8 wrap turns a stored 0 (meaning 8) into 7.
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o       = count_q;
    assign dec_to_zero_o = (pulses_from_count(count_q) == (CNT_W+1)'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - programmable burst of 1..8 registered pulses with abort and done strobe
//
// Ports:
//   clk_i        clock, rising edge
//   nreset_i     asynchronous active-low reset
//   start_i      request a burst, taken only while ready_o is high
//   count_i      pulses per burst (0 means 8)
//   abort_i      synchronous abort of a running burst
//   ready_o      high in IDLE only
//   pulse_o      registered pulse train
//   remaining_o  pulses not yet completed (8 reported as 0)
//   done_o       one-cycle strobe when the last low phase completes
module pulse_burst_gen
    import pulse_burst_gen_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 1,
    parameter int unsigned LOW_CYCLES  = 1
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             pulse_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             done_o
);

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(1);

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             pulse_q;
    logic             done_q;

    logic             busy;
    logic             abort_busy;
    logic             timer_expired;
    logic             cnt_load;
    logic             cnt_dec;
    logic             last_pulse;

    assign busy          = (state_q != ST_IDLE);
    assign abort_busy    = abort_i && busy;
    assign timer_expired = (timer_q == TMR_LAST);
    // Abort beats start even in IDLE.
    assign cnt_load      = (state_q == ST_IDLE) && start_i && !abort_i;
    assign cnt_dec       = (state_q == ST_LOW) && timer_expired && !abort_i;

    down_counter3 u_remaining (
        .clk_i         (clk_i),
        .nreset_i      (nreset_i),
        .clr_i         (abort_busy),
        .load_i        (cnt_load),
        .load_val_i    (count_i),
        .dec_i         (cnt_dec),
        .count_o       (remaining_o),
        .dec_to_zero_o (last_pulse)
    );

    // pulse_q is registered from the state, so it lags the state by one
    // clock: a HIGH state entered at the start edge drives pulse_o high from
    // the following edge, for exactly HIGH_CYCLES clocks.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pulse_q <= (state_q == ST_HIGH) && !abort_i;
            done_q  <= 1'b0;
            if (abort_busy) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q <= ST_HIGH;
                            timer_q <= HIGH_LOAD;
                        end
                    end
                    ST_HIGH: begin
                        if (timer_expired) begin
                            state_q <= ST_LOW;
                            timer_q <= LOW_LOAD;
                        end else begin
                            timer_q <= timer_q - TMR_LAST;
                        end
                    end
                    ST_LOW: begin
                        if (timer_expired) begin
                            if (last_pulse) begin
                                state_q <= ST_DONE;
                                timer_q <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_HIGH;
                                timer_q <= HIGH_LOAD;
                            end
                        end else begin
                            timer_q <= timer_q - TMR_LAST;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign pulse_o = pulse_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - directed self-checking bench for pulse_burst_gen
module tb_pulse_burst_gen;

    logic       clk = 1'b0;
    logic       nreset;

    logic       a_start, a_abort;
    logic [2:0] a_count;
    logic       a_ready, a_pulse, a_done;
    logic [2:0] a_rem;

    logic       b_start, b_abort;
    logic [2:0] b_count;
    logic       b_ready, b_pulse, b_done;
    logic [2:0] b_rem;

    logic [2:0] a_ctr;
    logic       ctr_clr;

    int checks   = 0;
    int failures = 0;

    int t1_p[7] = '{1, 0, 1, 0, 1, 0, 0};
    int t1_d[7] = '{0, 0, 0, 0, 0, 1, 0};
    int t1_r[7] = '{0, 0, 0, 0, 0, 0, 1};
    int t1_m[7] = '{3, 2, 2, 1, 1, 0, 0};

    int t6_p[10] = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    int t6_d[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int t6_r[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int t6_m[10] = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0};

    always #5 clk = ~clk;

    pulse_burst_gen dut_a (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .start_i     (a_start),
        .count_i     (a_count),
        .abort_i     (a_abort),
        .ready_o     (a_ready),
        .pulse_o     (a_pulse),
        .remaining_o (a_rem),
        .done_o      (a_done)
    );

    pulse_burst_gen #(.HIGH_CYCLES(2), .LOW_CYCLES(3)) dut_b (
        .clk_i       (clk),
        .nreset_i    (nreset),
        .start_i     (b_start),
        .count_i     (b_count),
        .abort_i     (b_abort),
        .ready_o     (b_ready),
        .pulse_o     (b_pulse),
        .remaining_o (b_rem),
        .done_o      (b_done)
    );

    // 3-bit counter clocked by the pulse train of dut_a.
    always @(posedge a_pulse or posedge ctr_clr) begin
        if (ctr_clr) a_ctr <= 3'd0;
        else         a_ctr <= a_ctr + 3'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_ctr();
        ctr_clr = 1'b1;
        #1;
        ctr_clr = 1'b0;
    endtask

    initial begin
        int rises;
        int n;
        logic prev;

        nreset  = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_count = 3'd0;
        b_start = 1'b0; b_abort = 1'b0; b_count = 3'd0;
        ctr_clr = 1'b0;
        clear_ctr();
        step();
        step();

        // reset state
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_pulse", a_pulse, 0);
        chk("rst_a_done",  a_done,  0);
        chk("rst_a_rem",   a_rem,   0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_pulse", b_pulse, 0);
        chk("rst_b_done",  b_done,  0);
        chk("rst_b_rem",   b_rem,   0);

        // defaults, count 3, started on first edge after reset release
        nreset  = 1'b1;
        a_count = 3'd3;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("t1_accept_ready", a_ready, 0);
        chk("t1_accept_pulse", a_pulse, 0);
        chk("t1_accept_rem",   a_rem,   3);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t1_pulse_%0d", k), a_pulse, t1_p[k-1]);
            chk($sformatf("t1_done_%0d",  k), a_done,  t1_d[k-1]);
            chk($sformatf("t1_ready_%0d", k), a_ready, t1_r[k-1]);
            chk($sformatf("t1_rem_%0d",   k), a_rem,   t1_m[k-1]);
        end

        // HIGH=2 LOW=3, count 0 means 8 pulses
        b_count = 3'd0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("t2_accept_rem",   b_rem,   0);
        chk("t2_accept_pulse", b_pulse, 0);
        rises = 0;
        prev  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk($sformatf("t2_pulse_%0d", k), b_pulse, (((k - 1) % 5) < 2) ? 1 : 0);
            chk($sformatf("t2_done_%0d",  k), b_done,  (k == 40) ? 1 : 0);
            chk($sformatf("t2_rem_%0d",   k), b_rem,   (8 - k / 5) & 7);
            if (b_pulse && !prev) rises++;
            prev = b_pulse;
        end
        chk("t2_rises", rises, 8);
        step();
        chk("t2_ready_after", b_ready, 1);
        chk("t2_done_after",  b_done,  0);

        // abort in the second HIGH phase
        a_count = 3'd5;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        chk("t3_pre_rem", a_rem, 4);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        chk("t3_pulse", a_pulse, 0);
        chk("t3_ready", a_ready, 1);
        chk("t3_done",  a_done,  0);
        chk("t3_rem",   a_rem,   0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t3_nodone_%0d", k), a_done,  0);
            chk($sformatf("t3_idle_%0d",   k), a_ready, 1);
        end

        // abort and start together in IDLE
        a_count = 3'd3;
        a_start = 1'b1;
        a_abort = 1'b1;
        step();
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("t4_ready", a_ready, 1);
        chk("t4_rem",   a_rem,   0);
        chk("t4_pulse", a_pulse, 0);
        step();
        chk("t4_ready2", a_ready, 1);

        // asynchronous reset mid-burst, then a fresh burst
        a_count = 3'd4;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        chk("t5_pulse_before", a_pulse, 1);
        #2;
        nreset = 1'b0;
        #1;
        chk("t5_async_pulse", a_pulse, 0);
        chk("t5_async_ready", a_ready, 1);
        chk("t5_async_rem",   a_rem,   0);
        chk("t5_async_done",  a_done,  0);
        step();
        nreset  = 1'b1;
        clear_ctr();
        a_count = 3'd4;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("t5_accept_rem", a_rem, 4);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t5_pulse_%0d", k), a_pulse, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("t5_done_%0d",  k), a_done,  (k == 8) ? 1 : 0);
            chk($sformatf("t5_rem_%0d",   k), a_rem,   4 - k / 2);
        end
        chk("t5_rises", a_ctr, 4);
        step();
        chk("t5_ready_after", a_ready, 1);

        // start held high: back-to-back bursts, mid-burst count change ignored
        a_count = 3'd2;
        a_start = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("t6_pulse_%0d", k), a_pulse, t6_p[k-1]);
            chk($sformatf("t6_done_%0d",  k), a_done,  t6_d[k-1]);
            chk($sformatf("t6_ready_%0d", k), a_ready, t6_r[k-1]);
            chk($sformatf("t6_rem_%0d",   k), a_rem,   t6_m[k-1]);
            if (k == 1) a_count = 3'd7;
            if (k == 4) a_count = 3'd2;
        end
        a_start = 1'b0;
        step();
        chk("t6_ready_after", a_ready, 1);
        step();
        chk("t6_stay_idle", a_ready, 1);

        // pulse train into a 3-bit counter, count 6, from reset
        nreset = 1'b0;
        step();
        nreset  = 1'b1;
        clear_ctr();
        a_count = 3'd6;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 0;
        while (!a_done && n < 40) begin
            step();
            n++;
        end
        chk("t7_done_seen",  a_done, 1);
        chk("t7_done_cycle", n,      12);
        chk("t7_counter",    a_ctr,  6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 Parameter: HIGH_CYCLES, default 1, clocks pulse_o stays high per pulse (legal 1..15).
REQ-002 Parameter: LOW_CYCLES, default 1, clocks pulse_o stays low between pulses (legal 1..15).
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: nreset_i  input  1  reset, asynchronous, active-low.
REQ-005 Port: start_i  input  1  request a burst; sampled only when ready_o=1.
REQ-006 Port: count_i  input  3  pulses per burst; 3'd0 encodes 8, otherwise the literal value.
REQ-007 Port: abort_i  input  1  synchronous abort of a running burst.
REQ-008 Port: ready_o  output  1  high only in IDLE; start_i accepted.
REQ-009 Port: pulse_o  output  1  registered pulse train, suitable to drive a 3-bit counter's pulse input.
REQ-010 Port: remaining_o  output  3  pulses not yet completed in current burst (8 reported as 3'd0).
REQ-011 Port: done_o  output  1  one-cycle strobe after last pulse's low phase completes.

Function
REQ-012 States: IDLE, HIGH, LOW, DONE; encoding from shared package.
REQ-013 IDLE: start_i=1 at edge t latches count_i into remaining counter, loads phase timer with HIGH_CYCLES, moves to HIGH; pulse_o=1 from edge t+1.
REQ-014 HIGH: pulse_o=1; phase timer decrements each clock; on expiry after exactly HIGH_CYCLES clocks -> LOW, timer loaded with LOW_CYCLES.
REQ-015 LOW: pulse_o=0; after exactly LOW_CYCLES clocks remaining decrements by 1; if result nonzero -> HIGH, else -> DONE.
REQ-016 Decrement from 8 (stored 3'd0) yields 7; wrap-around at 0 never occurs while busy because DONE is taken first.
REQ-017 DONE: done_o=1, pulse_o=0, ready_o=0 for exactly one clock, then IDLE.
REQ-018 Burst of N pulses: done_o asserted N*(HIGH_CYCLES+LOW_CYCLES) clocks after start edge; exactly N rising edges on pulse_o.
REQ-019 start_i while ready_o=0 ignored; no queuing.
REQ-020 count_i sampled only on accepting edge; later changes have no effect.
REQ-021 abort_i=1 in HIGH, LOW or DONE: next state IDLE, pulse_o=0 and done_o=0 next clock, remaining_o=0.
REQ-022 abort_i and start_i both high in IDLE: abort wins, start ignored, stay IDLE.
REQ-023 All outputs registered; no combinational path from inputs to outputs except ready_o derived from state register.

Reset
REQ-024 nreset_i low: immediately (no clock) state=IDLE, pulse_o=0, done_o=0, remaining_o=0, ready_o=1, phase timer=0.
REQ-025 Reset mid-burst truncates current pulse without waiting for clock; no done_o issued for aborted burst.
REQ-026 After nreset_i release, first start_i accepted on first rising edge with nreset_i high.

Structure
REQ-027 Shared package holds state typedef/encoding, count width (3), phase-timer width (4), and COUNT_ZERO_MEANS_8 constant.
REQ-028 Remaining-pulse tracking in one sub-module, down_counter3: load, decrement enable, async active-low reset, zero flag.
REQ-029 Phase timer and FSM in top module; total RTL 120-400 lines.

Verification
REQ-030 Defaults, count_i=3, start one clock -> pulse_o 1,0,1,0,1,0 on consecutive clocks, done_o at 6th clock after start, ready_o back next clock.
REQ-031 count_i=0, HIGH_CYCLES=2, LOW_CYCLES=3 -> 8 pulses each 2 high/3 low, done_o 40 clocks after start, remaining_o steps 0(8),7..1.
REQ-032 count_i=5, abort_i in 2nd HIGH phase -> pulse_o 0 and ready_o 1 next clock, no done_o, remaining_o=0.
REQ-033 nreset_i low asynchronously mid-LOW of count_i=4 burst -> outputs at reset values before next edge; new start after release gives full fresh burst.
REQ-034 start_i held high continuously with count_i=2 -> back-to-back bursts separated by one DONE clock and one IDLE accept clock; count_i change mid-burst ignored.
REQ-035 pulse_o driving a 3-bit up-counter with count_i=6 from reset -> counter reads 6 at done_o.
